// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a 2-entry skid buffer.
// The main entry drives the downstream side and the skid entry sits behind it.
// in_ready is a flop, so downstream stalls never reach upstream combinationally.
// Handshake: a payload moves on a rising edge where valid and ready are both 1.
// The sender holds valid and data steady until that edge.
// The stage also reports occupancy and keeps saturating stall/bubble counters.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [DATA_W-1:0]   main_q;
   logic [DATA_W-1:0]   skid_q;
   logic                out_valid_q;
   logic                in_ready_q;
   logic [1:0]          occ_q;
   logic [CNT_W-1:0]    stall_q, stall_d;
   logic [CNT_W-1:0]    bubble_q, bubble_d;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = occ_q;
   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;

   // Storage FSM: the state, the data entries and every handshake output are registered together.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else if (flush) begin
         // A squash drops both entries and any payload offered this cycle.
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_q      <= in_data;
                  state_q     <= ST_ONE;
                  out_valid_q <= 1'b1;
                  occ_q       <= 2'd1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  // The consumed entry is replaced in place and occupancy stays 1.
                  main_q <= in_data;
               end else if (in_fire) begin
                  skid_q     <= in_data;
                  state_q    <= ST_FULL;
                  in_ready_q <= 1'b0;
                  occ_q      <= 2'd2;
               end else if (out_fire) begin
                  // main_q keeps the last payload so out_data holds while empty.
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
                  occ_q       <= 2'd0;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_q     <= skid_q;
                  state_q    <= ST_ONE;
                  in_ready_q <= 1'b1;
                  occ_q      <= 2'd1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               occ_q       <= 2'd0;
            end
         endcase
      end
   end

   // Next counter values: step on a stall or bubble cycle, hold once all ones.
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (out_valid_q && !out_ready && !(&stall_q)) begin
         stall_d = stall_q + CNT_ONE;
      end
      if (!out_valid_q && out_ready && !(&bubble_q)) begin
         bubble_d = bubble_q + CNT_ONE;
      end
   end

   // Counter registers: only reset clears them, and a flush cycle still counts.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised next-generation inter-stage pipeline register for the 5-stage MIPS core; replaces the fixed-field enable/clear latches between IF/ID/EX/MEM/WB.
- Carries one packed control+datapath bundle of DATA_W bits using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready a pure register output, so stall back-pressure never forms a combinational path through the stage.
- Adds flush, occupancy reporting and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 32: width of the packed payload (control signals, instruction, PC+4, ALU results, write-register index).
- CNT_W, 16: width of each performance counter.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- clr_n, input, 1: reset, synchronous and active-low.
- flush, input, 1: synchronous pipeline flush (branch/jump squash); active-high.
- in_valid, input, 1: upstream stage presents a payload.
- in_ready, output, 1: stage can accept a payload; registered.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: payload available to the downstream stage.
- out_ready, input, 1: downstream accepts; low means stall.
- out_data, output, DATA_W: downstream payload; registered.
- occupancy, output, 2: number of held entries (0, 1 or 2).
- stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0.
- bubble_cnt, output, CNT_W: cycles with out_ready=1 and out_valid=0.

Behaviour:
- Handshakes: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready. Evaluated at the rising edge.
- Storage: main entry drives out_data/out_valid; skid entry is behind it. in_ready = !skid_valid.
- State machine (EMPTY: occupancy 0; ONE: main only; FULL: main+skid):
  - EMPTY: in-fire -> ONE, main <= in_data. Otherwise stay.
  - ONE, in-fire and out-fire -> ONE, main <= in_data.
  - ONE, in-fire only -> FULL, skid <= in_data.
  - ONE, out-fire only -> EMPTY.
  - ONE, neither -> stay, main held.
  - FULL: in_ready=0. Out-fire -> ONE, main <= skid. Otherwise stay, both held.
- Latency: in-fire at edge N gives out_valid=1 with that payload after edge N. Sustained throughput is 1 per cycle when out_ready=1.
- Ordering: strict FIFO; no payload is lost or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid are unchanged.
- Empty hold: when main drains, out_data keeps its last value and out_valid=0.
- Priority: clr_n=0 > flush > normal operation.
- Reset (clr_n=0 at an edge, including mid-transfer):
  - out_valid=0, out_data=0, skid cleared, in_ready=1, occupancy=0.
  - stall_cnt=0, bubble_cnt=0.
  - Any in-fire or out-fire in that cycle is ignored.
- Flush (flush=1 at an edge):
  - Both entries invalidated; out_data=0, skid data=0, in_ready=1, occupancy=0.
  - An in_data offered in the same cycle is discarded.
  - Counters are not cleared and still count that cycle per their rules.
- Counters:
  - Update every non-reset cycle from the pre-edge out_valid/out_ready.
  - Saturate at 2^CNT_W-1, with no wrap.
  - Never decrement; only clr_n clears them.
- Simultaneous in-fire and out-fire in ONE: occupancy stays 1 and the new payload replaces main.

Test Plan:
- Reset then stream 4 payloads 0x11..0x14 with out_ready=1 -> out_data 0x11..0x14 on consecutive cycles, one cycle after each input; in_ready stays 1; occupancy stays ≤1; stall_cnt=0.
- Push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0; 0xC held off upstream; stall_cnt increments each cycle. Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no loss.
- In FULL (0xA, 0xB), assert flush for one cycle with in_valid=1, in_data=0xD -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xD never appears.
- Hold out_ready=1, in_valid=0 for 5 cycles after reset -> bubble_cnt=5. Run CNT_W=4 with 20 stall cycles -> stall_cnt saturates at 15.
- Pull clr_n low for one edge while FULL with stall_cnt=7 -> all outputs 0, in_ready=1, stall_cnt=0; a push on the next cycle behaves as from EMPTY.
- Drive flush=1 and clr_n=0 together -> reset result, counters 0. Then drive flush=1 alone with out_valid=1, out_ready=0 -> stall_cnt still increments that cycle.
